// File: rtl/exception_pkg.sv
// Exception controller shared types: raw fault flags, exception record, cause codes, vector constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exception_pkg;

    // Raw per-instruction fault flags as collected down the pipeline.
    typedef struct packed {
        logic adel_if;
        logic tlbl_if;
        logic tlb_refill_if;
        logic ri;
        logic cpu;
        logic sys;
        logic bp;
        logic ov;
        logic adel;
        logic ades;
        logic tlbl;
        logic tlbs;
        logic tlb_refill_d;
        logic mod;
    } exc_flags_t;

    // Exception record handed to CP0 and the fetch redirect.
    typedef struct packed {
        logic        valid;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        in_delay_slot;
        logic [31:0] badvaddr;
        logic [31:0] location;
        logic [3:0]  ce;
    } exception_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VEC_BASE_BOOT   = 32'hBFC0_0200;
    localparam logic [31:0] VEC_BASE_NORMAL = 32'h8000_0000;
    localparam logic [31:0] VEC_OFS_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_OFS_INT     = 32'h0000_0200;
    localparam logic [31:0] VEC_OFS_GENERAL = 32'h0000_0180;

    // CP0 Status / Cause bit positions used here.
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_ERL = 2;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_IV   = 23;

endpackage

// File: rtl/exc_prio.sv
// Exception priority encoder: picks the winning cause code and the bad virtual address source.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the commit-stage flags.
// Ports: flags/int_pending/pc/dataaddr in; take (any cause), code, badvaddr, tlb_refill (winner is a refill miss) out.
module exc_prio
    import exception_pkg::*;
(
    input  exc_flags_t  flags,
    input  logic        int_pending,
    input  logic [31:0] pc,
    input  logic [31:0] dataaddr,
    output logic        take,
    output logic [4:0]  code,
    output logic [31:0] badvaddr,
    output logic        tlb_refill
);

    always_comb begin
        take       = 1'b1;
        code       = EXC_INT;
        badvaddr   = 32'h0;
        tlb_refill = 1'b0;
        if (int_pending) begin
            code = EXC_INT;
        end else if (flags.adel_if) begin
            code     = EXC_ADEL;
            badvaddr = pc;
        end else if (flags.tlbl_if || flags.tlb_refill_if) begin
            code       = EXC_TLBL;
            badvaddr   = pc;
            tlb_refill = flags.tlb_refill_if;
        end else if (flags.ri) begin
            code = EXC_RI;
        end else if (flags.cpu) begin
            code = EXC_CPU;
        end else if (flags.sys) begin
            code = EXC_SYS;
        end else if (flags.bp) begin
            code = EXC_BP;
        end else if (flags.ov) begin
            code = EXC_OV;
        end else if (flags.adel || flags.ades) begin
            code     = flags.adel ? EXC_ADEL : EXC_ADES;
            badvaddr = dataaddr;
        end else if (flags.tlbl || flags.tlbs || flags.tlb_refill_d) begin
            // A data refill miss carries no direction of its own; it reports as
            // a load miss unless the store flag is also raised.
            code       = (flags.tlbl || (flags.tlb_refill_d && !flags.tlbs)) ? EXC_TLBL : EXC_TLBS;
            badvaddr   = dataaddr;
            tlb_refill = flags.tlb_refill_d;
        end else if (flags.mod) begin
            code     = EXC_MOD;
            badvaddr = dataaddr;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception/interrupt/eret controller with flush sequencing and interrupt sync.
// Latency: exception_info.valid / is_eret pulse 1 cycle after the accepted commit.
// Backpressure: commit_ready drops for the whole flush until the cycle after flush_done.
// Ports: commit_* (instruction + flags), ext_int/timer_interrupt/cp0_status/cp0_cause, flush_done in;
//        commit_ready, flush, exception_info, is_eret, interrupt_info (Cause.IP) out.
module exception_ctrl
    import exception_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_in_delay_slot,
    input  logic [31:0] commit_dataaddr,
    input  exc_flags_t  commit_exc,
    input  logic [1:0]  commit_ce,
    input  logic        commit_is_eret,
    input  logic        commit_wr_status,
    input  logic [5:0]  ext_int,
    input  logic        timer_interrupt,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic        flush_done,
    output logic        commit_ready,
    output logic        flush,
    output exception_t  exception_info,
    output logic        is_eret,
    output logic [7:0]  interrupt_info
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state;
    logic [5:0]  int_sync1;
    logic [5:0]  int_sync2;
    logic        blackout;
    logic        int_pending;
    logic        take;
    logic [4:0]  code;
    logic [31:0] badvaddr;
    logic        tlb_refill;
    logic [31:0] vec_base;
    logic [31:0] vec_ofs;
    exception_t  next_info;

    // Status/Cause fields this block does not interpret.
    logic unused_cp0;
    assign unused_cp0 = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:3],
                          cp0_cause[31:24], cp0_cause[22:16], cp0_cause[7:0]};

    assign interrupt_info = {int_sync2[5] | timer_interrupt, int_sync2[4:0], 2'b00};

    // The blackout cycle after a Status/Cause write or eret lets the new
    // mask settle before an interrupt can be taken against it.
    assign int_pending = commit_valid && !blackout
                       && cp0_status[STATUS_IE] && !cp0_status[STATUS_EXL] && !cp0_status[STATUS_ERL]
                       && |(cp0_cause[15:8] & cp0_status[15:8]);

    exc_prio u_prio (
        .flags       (commit_exc),
        .int_pending (int_pending),
        .pc          (commit_pc),
        .dataaddr    (commit_dataaddr),
        .take        (take),
        .code        (code),
        .badvaddr    (badvaddr),
        .tlb_refill  (tlb_refill)
    );

    always_comb begin
        vec_base = cp0_status[STATUS_BEV] ? VEC_BASE_BOOT : VEC_BASE_NORMAL;
        if (tlb_refill && !cp0_status[STATUS_EXL]) begin
            vec_ofs = VEC_OFS_REFILL;
        end else if (code == EXC_INT && cp0_cause[CAUSE_IV]) begin
            vec_ofs = VEC_OFS_INT;
        end else begin
            vec_ofs = VEC_OFS_GENERAL;
        end
        next_info.valid         = 1'b1;
        next_info.code          = code;
        next_info.pc            = commit_pc;
        next_info.in_delay_slot = commit_in_delay_slot;
        next_info.badvaddr      = badvaddr;
        next_info.location      = vec_base + vec_ofs;
        next_info.ce            = (code == EXC_CPU) ? (4'b0001 << commit_ce) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            int_sync1      <= '0;
            int_sync2      <= '0;
            blackout       <= 1'b0;
            exception_info <= '0;
            is_eret        <= 1'b0;
            flush          <= 1'b0;
            commit_ready   <= 1'b1;
        end else begin
            int_sync1 <= ext_int;
            int_sync2 <= int_sync1;
            blackout  <= (state == IDLE) && commit_valid && (commit_wr_status || commit_is_eret);
            exception_info.valid <= 1'b0;
            is_eret              <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit_valid && (take || commit_is_eret)) begin
                        state        <= FLUSH;
                        flush        <= 1'b1;
                        commit_ready <= 1'b0;
                        // A faulting eret reports the fault, not the return.
                        if (take) begin
                            exception_info <= next_info;
                        end else begin
                            is_eret <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        state        <= IDLE;
                        flush        <= 1'b0;
                        commit_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: scoreboarded commit scenarios covering priority, vectors, interrupts, blackout, reset.
// Latency: expects each pulse one cycle after the commit.
// Backpressure: drives flush_done to release each flush.
module tb_exception_ctrl;
    import exception_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_in_delay_slot;
    logic [31:0] commit_dataaddr;
    exc_flags_t  commit_exc;
    logic [1:0]  commit_ce;
    logic        commit_is_eret;
    logic        commit_wr_status;
    logic [5:0]  ext_int;
    logic        timer_interrupt;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        flush_done;
    logic        commit_ready;
    logic        flush;
    exception_t  exception_info;
    logic        is_eret;
    logic [7:0]  interrupt_info;

    int n_cmp  = 0;
    int n_fail = 0;

    exception_t exp_q[$];
    logic       eret_q[$];

    always #5 clk = ~clk;

    exception_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .commit_valid         (commit_valid),
        .commit_pc            (commit_pc),
        .commit_in_delay_slot (commit_in_delay_slot),
        .commit_dataaddr      (commit_dataaddr),
        .commit_exc           (commit_exc),
        .commit_ce            (commit_ce),
        .commit_is_eret       (commit_is_eret),
        .commit_wr_status     (commit_wr_status),
        .ext_int              (ext_int),
        .timer_interrupt      (timer_interrupt),
        .cp0_status           (cp0_status),
        .cp0_cause            (cp0_cause),
        .flush_done           (flush_done),
        .commit_ready         (commit_ready),
        .flush                (flush),
        .exception_info       (exception_info),
        .is_eret              (is_eret),
        .interrupt_info       (interrupt_info)
    );

    function automatic exception_t mk(input logic vld, input logic [4:0] code, input logic [31:0] pc,
                                      input logic ds, input logic [31:0] bva, input logic [31:0] loc,
                                      input logic [3:0] ce);
        exception_t e;
        e.valid = vld; e.code = code; e.pc = pc; e.in_delay_slot = ds;
        e.badvaddr = bva; e.location = loc; e.ce = ce;
        return e;
    endfunction

    task automatic idle_inputs();
        commit_valid = 1'b0; commit_exc = '0; commit_is_eret = 1'b0; commit_wr_status = 1'b0;
        commit_ce = 2'd0; commit_in_delay_slot = 1'b0; commit_pc = '0; commit_dataaddr = '0;
    endtask

    // Called at a negedge: presents one commit for one cycle, records the expectation,
    // returns at the next negedge (pulse cycle) with the commit still presented.
    task automatic drive_commit(input exc_flags_t f, input logic [31:0] pc, input logic [31:0] da,
                                input logic ds, input logic [1:0] ce, input logic eret, input logic wrs,
                                input exception_t exp, input logic exp_eret);
        commit_valid = 1'b1; commit_exc = f; commit_pc = pc; commit_dataaddr = da;
        commit_in_delay_slot = ds; commit_ce = ce; commit_is_eret = eret; commit_wr_status = wrs;
        exp_q.push_back(exp);
        eret_q.push_back(exp_eret);
        @(negedge clk);
    endtask

    // Holds the flush for some cycles, then releases it and expects IDLE.
    task automatic drain_flush(input string name, input int hold);
        idle_inputs();
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({flush, commit_ready, exception_info.valid, is_eret} !== 4'b1000) begin
                n_fail++;
                $display("FAIL %s_flush_hold: {flush,ready,valid,eret}=%b want 1000", name,
                         {flush, commit_ready, exception_info.valid, is_eret});
            end
        end
        flush_done = 1'b1;
        @(negedge clk);
        flush_done = 1'b0;
        n_cmp++;
        if ({flush, commit_ready, exception_info.valid, is_eret} !== 4'b0100) begin
            n_fail++;
            $display("FAIL %s_flush_exit: {flush,ready,valid,eret}=%b want 0100", name,
                     {flush, commit_ready, exception_info.valid, is_eret});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs(); ext_int = '0; timer_interrupt = 1'b0;
        cp0_status = '0; cp0_cause = '0; flush_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({commit_ready, flush, is_eret} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctl: {ready,flush,eret}=%b want 100", {commit_ready, flush, is_eret});
        end
        n_cmp++;
        if (exception_info !== exception_t'(0)) begin
            n_fail++;
            $display("FAIL reset_info: got %h want 0", exception_info);
        end
        n_cmp++;
        if (interrupt_info !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ip: got %h want 00", interrupt_info);
        end
    endtask

    task automatic test_ri();
        exc_flags_t f;
        exception_t e;
        logic       er;
        f = '0; f.ri = 1'b1;
        drive_commit(f, 32'h8000_1000, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0,
                     mk(1'b1, EXC_RI, 32'h8000_1000, 1'b0, 32'h0, 32'h8000_0180, 4'h0), 1'b0);
        e = exp_q.pop_front(); er = eret_q.pop_front();
        n_cmp++;
        if (exception_info !== e || is_eret !== er) begin
            n_fail++;
            $display("FAIL ri: got %h/%b want %h/%b", exception_info, is_eret, e, er);
        end
        n_cmp++;
        if ({flush, commit_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL ri_pulse_ctl: {flush,ready}=%b want 10", {flush, commit_ready});
        end
        drain_flush("ri", 3);
    endtask

    task automatic test_tlb_refill();
        exc_flags_t f;
        exception_t e;
        f = '0; f.tlb_refill_d = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            cp0_status = (pass == 0) ? 32'h0 : 32'h0000_0002;
            drive_commit(f, 32'h8000_3000, 32'h0040_0004, 1'b0, 2'd0, 1'b0, 1'b0,
                         mk(1'b1, EXC_TLBL, 32'h8000_3000, 1'b0, 32'h0040_0004,
                            (pass == 0) ? 32'h8000_0000 : 32'h8000_0180, 4'h0), 1'b0);
            e = exp_q.pop_front(); void'(eret_q.pop_front());
            n_cmp++;
            if (exception_info !== e) begin
                n_fail++;
                $display("FAIL tlb_refill_exl%0d: got %h want %h", pass, exception_info, e);
            end
            drain_flush("tlb_refill", 1);
        end
        cp0_status = '0;
    endtask

    task automatic test_priority();
        exc_flags_t f;
        exception_t e;
        logic [4:0]  code;
        logic [1:0]  sel;
        logic        eret, er;
        logic [31:0] pc, da, bva;
        cp0_status = 32'h0040_0000; // BEV=1 -> boot vectors
        for (int i = 0; i < 12; i++) begin
            f = '0; eret = 1'b0;
            pc = 32'h9000_0000 + 32'(i * 4);
            da = 32'h1234_5000 + 32'(i * 8);
            case (i)
                0:  begin f.ov = 1; f.adel_if = 1;   code = EXC_ADEL; sel = 1; end
                1:  begin f.sys = 1; eret = 1;       code = EXC_SYS;  sel = 0; end
                2:  begin f.sys = 1; f.bp = 1;       code = EXC_SYS;  sel = 0; end
                3:  begin f.bp = 1; f.ov = 1;        code = EXC_BP;   sel = 0; end
                4:  begin f.cpu = 1; f.ri = 1;       code = EXC_RI;   sel = 0; end
                5:  begin f.cpu = 1; f.sys = 1;      code = EXC_CPU;  sel = 0; end
                6:  begin f.tlbl_if = 1; f.ri = 1;   code = EXC_TLBL; sel = 1; end
                7:  begin f.adel = 1; f.tlbs = 1;    code = EXC_ADEL; sel = 2; end
                8:  begin f.ades = 1; f.mod = 1;     code = EXC_ADES; sel = 2; end
                9:  begin f.tlbs = 1; f.mod = 1;     code = EXC_TLBS; sel = 2; end
                10: begin f.mod = 1;                 code = EXC_MOD;  sel = 2; end
                default: begin f.ov = 1;             code = EXC_OV;   sel = 0; end
            endcase
            bva = (sel == 1) ? pc : (sel == 2) ? da : 32'h0;
            drive_commit(f, pc, da, (i % 2) == 1, 2'd2, eret, 1'b0,
                         mk(1'b1, code, pc, (i % 2) == 1, bva, 32'hBFC0_0380,
                            (code == EXC_CPU) ? 4'b0100 : 4'b0000), 1'b0);
            e = exp_q.pop_front(); er = eret_q.pop_front();
            n_cmp++;
            if (exception_info !== e || is_eret !== er) begin
                n_fail++;
                $display("FAIL prio_%0d: got %h/%b want %h/%b", i, exception_info, is_eret, e, er);
            end
            drain_flush("prio", 1);
        end
        cp0_status = '0;
    endtask

    task automatic test_eret();
        exception_t e;
        logic       er;
        drive_commit('0, 32'h8000_4000, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0, exception_t'(0), 1'b1);
        e = exp_q.pop_front(); er = eret_q.pop_front();
        n_cmp++;
        if (exception_info.valid !== e.valid || is_eret !== er) begin
            n_fail++;
            $display("FAIL eret: valid/eret=%b/%b want %b/%b", exception_info.valid, is_eret, e.valid, er);
        end
        drain_flush("eret", 2);
    endtask

    task automatic test_interrupt();
        exception_t e;
        cp0_status = 32'h0000_1001; // IE, IM[4]
        cp0_cause  = 32'h0;
        ext_int    = 6'b000100;
        @(negedge clk);
        n_cmp++;
        if (interrupt_info !== 8'h00) begin
            n_fail++;
            $display("FAIL ip_sync_1cyc: got %h want 00", interrupt_info);
        end
        @(negedge clk);
        n_cmp++;
        if (interrupt_info !== 8'h10) begin
            n_fail++;
            $display("FAIL ip_sync_2cyc: got %h want 10", interrupt_info);
        end
        timer_interrupt = 1'b1;
        #1;
        n_cmp++;
        if (interrupt_info !== 8'h90) begin
            n_fail++;
            $display("FAIL ip_timer: got %h want 90", interrupt_info);
        end
        timer_interrupt = 1'b0;
        // Cause.IP not yet updated: nothing is pending.
        drive_commit('0, 32'h8000_2000, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, exception_t'(0), 1'b0);
        e = exp_q.pop_front(); void'(eret_q.pop_front());
        n_cmp++;
        if (exception_info.valid !== e.valid || commit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL int_not_pending: valid/ready=%b/%b want 0/1", exception_info.valid, commit_ready);
        end
        for (int iv = 0; iv < 2; iv++) begin
            cp0_cause = (iv == 0) ? 32'h0000_1000 : 32'h0080_1000;
            drive_commit('0, 32'h8000_2004, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0,
                         mk(1'b1, EXC_INT, 32'h8000_2004, 1'b1, 32'h0,
                            (iv == 0) ? 32'h8000_0180 : 32'h8000_0200, 4'h0), 1'b0);
            e = exp_q.pop_front(); void'(eret_q.pop_front());
            n_cmp++;
            if (exception_info !== e) begin
                n_fail++;
                $display("FAIL int_iv%0d: got %h want %h", iv, exception_info, e);
            end
            drain_flush("int", 1);
        end
        cp0_status = 32'h0000_1003; // EXL masks the interrupt
        drive_commit('0, 32'h8000_2008, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, exception_t'(0), 1'b0);
        e = exp_q.pop_front(); void'(eret_q.pop_front());
        n_cmp++;
        if (exception_info.valid !== e.valid) begin
            n_fail++;
            $display("FAIL int_exl_masked: valid=%b want 0", exception_info.valid);
        end
        idle_inputs();
    endtask

    task automatic test_blackout();
        exception_t e;
        cp0_status = 32'h0000_1000; // IE=0 while the mtc0 commits
        cp0_cause  = 32'h0000_1000;
        @(negedge clk);
        drive_commit('0, 32'h8000_5000, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1, exception_t'(0), 1'b0);
        e = exp_q.pop_front(); void'(eret_q.pop_front());
        n_cmp++;
        if (exception_info.valid !== e.valid) begin
            n_fail++;
            $display("FAIL mtc0_commit: valid=%b want 0", exception_info.valid);
        end
        cp0_status = 32'h0000_1001;
        drive_commit('0, 32'h8000_5004, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, exception_t'(0), 1'b0);
        e = exp_q.pop_front(); void'(eret_q.pop_front());
        n_cmp++;
        if (exception_info.valid !== e.valid) begin
            n_fail++;
            $display("FAIL blackout: valid=%b want 0", exception_info.valid);
        end
        drive_commit('0, 32'h8000_5008, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0,
                     mk(1'b1, EXC_INT, 32'h8000_5008, 1'b0, 32'h0, 32'h8000_0180, 4'h0), 1'b0);
        e = exp_q.pop_front(); void'(eret_q.pop_front());
        n_cmp++;
        if (exception_info !== e) begin
            n_fail++;
            $display("FAIL after_blackout: got %h want %h", exception_info, e);
        end
        drain_flush("blackout", 1);
        cp0_status = '0; cp0_cause = '0; ext_int = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_flush();
        exc_flags_t f;
        exception_t e;
        f = '0; f.ov = 1'b1;
        drive_commit(f, 32'h8000_6000, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0,
                     mk(1'b1, EXC_OV, 32'h8000_6000, 1'b0, 32'h0, 32'h8000_0180, 4'h0), 1'b0);
        e = exp_q.pop_front(); void'(eret_q.pop_front());
        n_cmp++;
        if (exception_info !== e) begin
            n_fail++;
            $display("FAIL pre_reset_ov: got %h want %h", exception_info, e);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({flush, commit_ready, exception_info.valid, is_eret} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_mid_flush: {flush,ready,valid,eret}=%b want 0100",
                     {flush, commit_ready, exception_info.valid, is_eret});
        end
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if ({flush, commit_ready, exception_info.valid, is_eret} !== 4'b0100) begin
            n_fail++;
            $display("FAIL after_reset_no_pulse: {flush,ready,valid,eret}=%b want 0100",
                     {flush, commit_ready, exception_info.valid, is_eret});
        end
    endtask

    initial begin
        test_reset();
        test_ri();
        test_tlb_refill();
        test_priority();
        test_eret();
        test_interrupt();
        test_blackout();
        test_reset_mid_flush();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous, active-high); no other clock or reset exists.
REQ-002 SHALL have commit_valid (in, 1): instruction present at the commit stage.
REQ-003 SHALL have commit_pc (in, 32), commit_in_delay_slot (in, 1) and commit_dataaddr (in, 32): faulting load/store address.
REQ-004 SHALL have commit_exc (in, exc_flags_t) with raw flags adel_if, tlbl_if, tlb_refill_if, ri, cpu, sys, bp, ov, adel, ades, tlbl, tlbs, tlb_refill_d, mod.
REQ-005 SHALL have commit_ce (in, 2): coprocessor number for CpU.
REQ-006 SHALL have commit_is_eret (in, 1) and commit_wr_status (in, 1): mtc0 to Status or Cause.
REQ-007 SHALL have ext_int (in, 6, asynchronous), timer_interrupt (in, 1), cp0_status (in, 32) and cp0_cause (in, 32).
REQ-008 SHALL have flush_done (in, 1): pipeline drained.
REQ-009 SHALL have commit_ready (out, 1) and flush (out, 1).
REQ-010 SHALL have exception_info (out, exception_t): valid, code[4:0], pc, in_delay_slot, badvaddr, location, ce[3:0] one-hot.
REQ-011 SHALL have is_eret (out, 1) and interrupt_info (out, 8) driving Cause.IP.

Function
REQ-012 ext_int SHALL pass a 2-flop synchronizer; interrupt_info[7:2] SHALL equal {sync[5]|timer_interrupt, sync[4:0]}, interrupt_info[1:0]=0.
REQ-013 Interrupt pending SHALL be Status.IE & ~EXL & ~ERL & |(Cause.IP & Status.IM), evaluated only with commit_valid.
REQ-014 For exactly 1 cycle after an accepted commit_wr_status or eret, interrupt pending SHALL be forced 0 (blackout).
REQ-015 Priority SHALL be: Int(0) > AdEL-fetch(4) > TLBL-fetch(2) > RI(10) > CpU(11) > Sys(8) = Bp(9), Sys first > Ov(12) > AdEL(4)/AdES(5) > TLBL(2)/TLBS(3) > Mod(1).
REQ-016 badvaddr SHALL be commit_pc for fetch faults, commit_dataaddr for data faults, else 0.
REQ-017 location base SHALL be 0xBFC00200 if Status.BEV, else 0x80000000.
REQ-018 Offset SHALL be 0x000 for TLB refill with EXL=0, 0x200 for Int with Cause.IV=1, else 0x180.
REQ-019 ce SHALL be one-hot of commit_ce when code=CpU, else 0.
REQ-020 FSM states SHALL be IDLE and FLUSH.
REQ-021 In IDLE, commit_valid & (any exception | interrupt | eret) SHALL drive a registered 1-cycle pulse of exception_info.valid or is_eret, then enter FLUSH.
REQ-022 Exception and eret on the same instruction SHALL produce the exception only.
REQ-023 In FLUSH: flush=1, commit_ready=0, outputs valid/is_eret=0; return to IDLE the cycle after flush_done=1.
REQ-024 flush_done in IDLE SHALL be ignored; commit_ready=1 in IDLE.
REQ-025 Latency from accepted commit to pulse SHALL be 1 cycle.

Reset
REQ-026 Reset SHALL force IDLE, clear synchronizers and blackout, and set all outputs 0 except commit_ready=1.
REQ-027 Reset during FLUSH SHALL abandon the flush; no pulse SHALL appear in the following cycle.

Structure
REQ-028 exc_flags_t, exception_t, the EXC_* code constants and vector base/offset constants SHALL live in exception_pkg.
REQ-029 Priority selection SHALL be the combinational sub-module exc_prio (flags -> code, badvaddr select); the FSM, synchronizer and blackout SHALL stay in exception_ctrl.

Verification
REQ-030 ri=1, pc=0x80001000, BEV=0, EXL=0: expect next-cycle valid, code=10, location=0x80000180, then flush until flush_done.
REQ-031 tlb_refill_d, dataaddr=0x00400004, EXL=0: expect code=2, badvaddr=0x00400004, location=0x80000000; repeat with EXL=1: expect 0x80000180.
REQ-032 ext_int[2]=1, IM[4]=1, IE=1: expect IP[4] set 2 cycles later; next valid commit gives code=0.
REQ-033 IV=1: expect location 0x80000200.
REQ-034 Simultaneous ov and adel_if: expect code=4, badvaddr=pc; eret with sys: expect code=8, is_eret=0.
REQ-035 mtc0 Status commit followed immediately by a pending interrupt: expect no interrupt in the blackout cycle, taken one cycle later.
REQ-036 Reset asserted mid-FLUSH: expect IDLE, commit_ready=1, no pulse.
